// File: rtl/cpu5_alu_md.sv
// ============================================================================
// Module   : cpu5_alu_md
// Brief    : Handshaked ALU with iterative shift-add multiply and restoring
//            unsigned divide/remainder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu5_alu_md #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [CTRL_W-1:0] control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   y,
  output logic              zero,
  output logic              illegal
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] c_cnt_init = CW'(XLEN);
  localparam logic [CW-1:0] c_cnt_last = CW'(1);

  localparam logic [CTRL_W-1:0] c_op_and  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] c_op_or   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] c_op_add  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] c_op_sub  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] c_op_slt  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] c_op_mul  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] c_op_divu = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] c_op_remu = CTRL_W'(4'b1101);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc;   // product (MUL) or partial remainder (DIV)
  logic [XLEN-1:0] r_opa;   // shifting multiplicand (MUL) or dividend/quotient (DIV)
  logic [XLEN-1:0] r_opb;   // shifting multiplier (MUL) or divisor (DIV)
  logic            r_is_mul;
  logic            r_is_divu;

  logic [XLEN-1:0] w_fast_y;
  logic            w_fast_ill;
  logic            w_slow;
  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0] w_opa_nxt;
  logic [XLEN-1:0] w_opb_nxt;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_busy_y;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  // Single-cycle results, plus the decision whether the request needs the iterative path.
  always_comb begin
    w_fast_y   = '0;
    w_fast_ill = 1'b0;
    w_slow     = 1'b0;
    case (control)
      c_op_and:  w_fast_y = a & b;
      c_op_or:   w_fast_y = a | b;
      c_op_add:  w_fast_y = a + b;
      c_op_sub:  w_fast_y = a - b;
      c_op_slt:  w_fast_y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      c_op_mul:  w_slow   = 1'b1;
      c_op_divu: begin
        w_fast_y = '1;
        w_slow   = (b != '0);
      end
      c_op_remu: begin
        w_fast_y = a;
        w_slow   = (b != '0);
      end
      default:   w_fast_ill = 1'b1;
    endcase
  end

  assign w_shift = {r_acc, r_opa[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};

  always_comb begin
    w_acc_nxt = r_acc;
    w_opa_nxt = r_opa;
    w_opb_nxt = r_opb;
    if (r_is_mul) begin
      w_acc_nxt = r_acc + (r_opb[0] ? r_opa : '0);
      w_opa_nxt = r_opa << 1;
      w_opb_nxt = r_opb >> 1;
    end else if (!w_diff[XLEN]) begin
      w_acc_nxt = w_diff[XLEN-1:0];
      w_opa_nxt = {r_opa[XLEN-2:0], 1'b1};
    end else begin
      w_acc_nxt = w_shift[XLEN-1:0];
      w_opa_nxt = {r_opa[XLEN-2:0], 1'b0};
    end
  end

  assign w_busy_y = r_is_divu ? w_opa_nxt : w_acc_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_is_mul  <= 1'b0;
      r_is_divu <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_slow) begin
              r_state   <= S_BUSY;
              r_cnt     <= c_cnt_init;
              r_acc     <= '0;
              r_opa     <= a;
              r_opb     <= b;
              r_is_mul  <= (control == c_op_mul);
              r_is_divu <= (control == c_op_divu);
            end else begin
              r_state <= S_DONE;
              y       <= w_fast_y;
              zero    <= !w_fast_ill && (w_fast_y == '0);
              illegal <= w_fast_ill;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_opa <= w_opa_nxt;
          r_opb <= w_opb_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_state <= S_DONE;
            y       <= w_busy_y;
            zero    <= (w_busy_y == '0);
            illegal <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu5_alu_md.sv
// ============================================================================
// Module   : tb_cpu5_alu_md
// Brief    : Self-checking bench for cpu5_alu_md against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu5_alu_md;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      control;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] y;
  logic            zero;
  logic            illegal;

  int n_err = 0;
  int n_chk = 0;

  cpu5_alu_md #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ill(input logic [3:0] op);
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13});
  endfunction

  function automatic logic model_slow(input logic [3:0] op, input logic [31:0] vb);
    return (op == 4'd8) || ((op == 4'd12 || op == 4'd13) && vb != 0);
  endfunction

  function automatic logic [31:0] model_y(input logic [3:0] op, input logic [31:0] va,
                                          input logic [31:0] vb);
    logic [63:0] prod;
    case (op)
      4'd0:  return va & vb;
      4'd1:  return va | vb;
      4'd2:  return va + vb;
      4'd6:  return va - vb;
      4'd7:  return ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
      4'd8:  begin prod = 64'(va) * 64'(vb); return prod[31:0]; end
      4'd12: return (vb == 0) ? 32'hFFFF_FFFF : va / vb;
      4'd13: return (vb == 0) ? va : va % vb;
      default: return 32'd0;
    endcase
  endfunction

  // One full transaction: issue, wait for result, hold it, then release it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input int hold, input bit poke);
    logic [31:0] ey;
    int n;
    bit got;
    bit ready_seen;
    ey = model_y(op, va, vb);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    control  = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    got = 0;
    ready_seen = 0;
    while (n < 100) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
      if (in_ready) ready_seen = 1;
      if (poke) begin
        in_valid = 1'($urandom);
        a        = $urandom;
        b        = $urandom;
        control  = 4'($urandom);
      end
      @(posedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({tag, ".got"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(n), model_slow(op, vb) ? 64'(XLEN) : 64'd0);
    chk({tag, ".ready_busy"}, 64'(ready_seen), 64'd0);
    chk({tag, ".y"}, 64'(y), 64'(ey));
    chk({tag, ".zero"}, 64'(zero), 64'(!model_ill(op) && ey == 0));
    chk({tag, ".illegal"}, 64'(illegal), 64'(model_ill(op)));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_y"}, 64'(y), 64'(ey));
      chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".valid_after"}, 64'(out_valid), 64'd0);
    chk({tag, ".ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, ".y_kept"}, 64'(y), 64'(ey));
  endtask

  logic [3:0] legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13};

  initial begin
    logic [3:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    control   = '0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.y", 64'(y), 64'd0);
    chk("rst.zero", 64'(zero), 64'd0);
    chk("rst.illegal", 64'(illegal), 64'd0);
    reset = 1'b0;

    run_op("add_wrap", 4'd2, 32'd5, 32'hFFFF_FFFB, 0, 0);
    run_op("sub", 4'd6, 32'd3, 32'd5, 0, 0);
    run_op("slt", 4'd7, 32'h8000_0000, 32'd1, 0, 0);
    run_op("slt_neg", 4'd7, 32'd1, 32'h8000_0000, 0, 0);
    run_op("mul", 4'd8, 32'h0001_0000, 32'h0001_0001, 0, 0);
    run_op("divu", 4'd12, 32'd100, 32'd7, 5, 1);
    run_op("remu", 4'd13, 32'd100, 32'd7, 0, 1);
    run_op("divu_z", 4'd12, 32'd9, 32'd0, 0, 0);
    run_op("remu_z", 4'd13, 32'd9, 32'd0, 0, 0);
    run_op("divu_big", 4'd12, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_op("remu_big", 4'd13, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0);
    run_op("illegal", 4'd3, 32'd1, 32'd2, 2, 0);
    run_op("and_after", 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0);

    // Reset in the middle of a division, then a fresh ADD.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'd100;
    b        = 32'd7;
    control  = 4'd12;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.y", 64'(y), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst_add", 4'd2, 32'd1, 32'd1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), op, ra, rb, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu5_alu_md.md
CPU5_ALU_MD -- requirements
Module: cpu5_alu_md

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning operand/result width in bits (legal values 8..64, powers of two).
REQ-002 SHALL provide parameter CTRL_W, default 4, meaning width of the operation code.
REQ-003 SHALL provide port clk  input  1  rising-edge clock; single clock domain.
REQ-004 SHALL provide port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port in_valid  input  1  operation request present.
REQ-006 SHALL provide port in_ready  output  1  block can accept a request.
REQ-007 SHALL provide port a  input  XLEN  operand A (dividend, multiplicand).
REQ-008 SHALL provide port b  input  XLEN  operand B (divisor, multiplier).
REQ-009 SHALL provide port control  input  CTRL_W  operation code.
REQ-010 SHALL provide port out_valid  output  1  result present.
REQ-011 SHALL provide port out_ready  input  1  consumer takes result.
REQ-012 SHALL provide port y  output  XLEN  result.
REQ-013 SHALL provide port zero  output  1  result equals 0, legal opcodes only.
REQ-014 SHALL provide port illegal  output  1  accepted opcode was unsupported.

Function
REQ-015 SHALL decode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, y=1 or 0), 1000 MUL (low XLEN bits, unsigned), 1100 DIVU, 1101 REMU; all others illegal.
REQ-016 SHALL accept a request on the rising edge where in_valid and in_ready are both 1, capturing a, b, control; inputs outside that edge are ignored.
REQ-017 SHALL implement FSM IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 SHALL transition IDLE->DONE on accept of AND/OR/ADD/SUB/SLT, illegal opcode, or DIVU/REMU with b=0; out_valid rises 1 cycle after accept.
REQ-019 SHALL transition IDLE->BUSY on accept of MUL, or DIVU/REMU with b!=0, and BUSY->DONE after exactly XLEN cycles in BUSY; out_valid rises XLEN+1 cycles after accept.
REQ-020 SHALL compute MUL by iterative shift-add, one multiplier bit per BUSY cycle, with a log2(XLEN)+1-bit iteration counter.
REQ-021 SHALL compute DIVU/REMU by restoring division, one quotient bit per BUSY cycle; DIVU y=quotient, REMU y=remainder.
REQ-022 SHALL return, for b=0: DIVU y=all ones, REMU y=a, zero per result value, illegal=0.
REQ-023 SHALL wrap ADD/SUB/MUL modulo 2^XLEN with no overflow flag.
REQ-024 SHALL return, for illegal opcodes: y=0, zero=0, illegal=1.
REQ-025 SHALL hold y, zero, illegal stable in DONE until out_ready=1; DONE->IDLE on that edge.
REQ-026 SHALL keep in_ready=0 in DONE even when out_ready=1 (no same-cycle re-accept); next accept no earlier than the cycle after leaving DONE.
REQ-027 SHALL ignore in_valid while BUSY or DONE, with no side effects on the in-flight operation.
REQ-028 SHALL leave y, zero, illegal holding the last result while not in DONE; consumers qualify with out_valid.

Reset
REQ-029 SHALL, on reset=1 at any time including mid-BUSY or DONE, immediately force state=IDLE, in_ready=1 after release, out_valid=0, y=0, zero=0, illegal=0, counter=0, and discard the in-flight operation.
REQ-030 SHALL, after reset deassertion, accept a request on the first rising edge with in_valid=1.

Verification
REQ-031 SHALL verify (XLEN=32): ADD a=5 b=0xFFFFFFFB, out_ready=1 -> out_valid 1 cycle after accept, y=0, zero=1; SUB 3-5 -> y=0xFFFFFFFE, zero=0; SLT 0x80000000<1 -> y=1.
REQ-032 SHALL verify: MUL a=0x10000 b=0x10001 -> out_valid exactly 33 cycles after accept, y=0x00010000, in_ready=0 throughout.
REQ-033 SHALL verify: DIVU 100/7 -> y=14 at accept+33; REMU 100/7 -> y=2; DIVU 9/0 -> y=0xFFFFFFFF at accept+1; REMU 9/0 -> y=9.
REQ-034 SHALL verify: out_ready held 0 for 5 cycles in DONE -> out_valid and y stable for all 5; in_valid pulsed during BUSY -> no second result.
REQ-035 SHALL verify: reset asserted mid-DIVU (cycle 10 of BUSY) -> out_valid=0 immediately, in_ready=1 after release, then ADD 1+1 -> y=2 at accept+1.
REQ-036 SHALL verify: control=0011 -> y=0, zero=0, illegal=1 at accept+1; following legal op -> illegal=0.
